// File: rtl/inv_mix_cols_seq.sv
// Inverse MixColumns for the AES-128 decryption round.
// Captures a 4x4 byte state, transforms COLS_PER_CYCLE columns per clock in
// place, then presents the result until the downstream handshake completes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   Datain holds a valid state
//   in_ready   block can accept a state (IDLE and not in reset)
//   Datain     input state, [row][col] bytes
//   out_valid  Dataout holds a valid result
//   out_ready  downstream accepts the result
//   Dataout    result state, [row][col] bytes; holds the last result in IDLE
//
// state | meaning
// IDLE  | waiting for an input state
// BUSY  | transforming columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 each edge
// DONE  | result presented, waiting for out_ready

module inv_mix_cols_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [0:3][0:3][7:0]   Datain,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [0:3][0:3][7:0]   Dataout
);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
         $error("inv_mix_cols_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             col_cnt_q;
   logic [0:3][0:3][7:0]   work_q, work_d;
   logic [2:0]             col_lo, col_hi;
   logic                   last_step;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [0:3][7:0] inv_col(input logic [0:3][7:0] a);
      logic [0:3][7:0] m9, mb, md, me, r;
      logic [7:0]      x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      r[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
      return r;
   endfunction

   // col_cnt is always a multiple of COLS_PER_CYCLE, so the window never wraps;
   // a 3-bit upper bound lets the last step reach 4 cleanly.
   assign col_lo    = {1'b0, col_cnt_q};
   assign col_hi    = col_lo + 3'(COLS_PER_CYCLE);
   assign last_step = (col_hi == 3'd4);

   always_comb begin
      logic [0:3][7:0] col_in, col_out;
      work_d  = work_q;
      col_in  = '0;
      col_out = '0;
      for (int c = 0; c < 4; c++) begin
         if ((3'(c) >= col_lo) && (3'(c) < col_hi)) begin
            for (int r = 0; r < 4; r++) col_in[r] = work_q[r][c];
            col_out = inv_col(col_in);
            for (int r = 0; r < 4; r++) work_d[r][c] = col_out[r];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      in_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) state_d = BUSY;
         end
         BUSY: begin
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         col_cnt_q <= '0;
         work_q    <= '0;
         Dataout   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  work_q    <= Datain;
                  col_cnt_q <= '0;
               end
            end
            BUSY: begin
               work_q    <= work_d;
               col_cnt_q <= col_hi[1:0];
               if (last_step) Dataout <= work_d;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_cols_seq.sv
module tb_inv_mix_cols_seq;

   typedef logic [0:3][0:3][7:0] state_t;

   typedef struct {
      string  name;
      state_t din;
      state_t exp;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst;
   logic   in_valid  [3];
   logic   in_ready  [3];
   logic   out_valid [3];
   logic   out_ready [3];
   state_t din       [3];
   state_t dout      [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Instance 0: 1 column/cycle, 1: 2 columns/cycle, 2: 4 columns/cycle
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      inv_mix_cols_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .Datain    (din[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .Dataout   (dout[g])
      );
   end

   function automatic int cpc_of(int i);
      return (i == 0) ? 1 : (i == 1) ? 2 : 4;
   endfunction

   function automatic state_t mk(logic [31:0] c0, logic [31:0] c1,
                                 logic [31:0] c2, logic [31:0] c3);
      logic [31:0] cs [4];
      state_t s;
      cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = cs[c][8*(3-r) +: 8];
      return s;
   endfunction

   function automatic logic [7:0] x2(logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Forward MixColumns, used to build round-trip stimulus.
   function automatic state_t fwd_mix(state_t s);
      state_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
         o[0][c] = x2(a0) ^ (x2(a1) ^ a1) ^ a2 ^ a3;
         o[1][c] = a0 ^ x2(a1) ^ (x2(a2) ^ a2) ^ a3;
         o[2][c] = a0 ^ a1 ^ x2(a2) ^ (x2(a3) ^ a3);
         o[3][c] = (x2(a0) ^ a0) ^ a1 ^ a2 ^ x2(a3);
      end
      return o;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Send one state to instance i, optionally hold off out_ready for `hold`
   // cycles after out_valid, then complete the output handshake.
   task automatic run_one(int i, state_t st, int hold, bit rand_rdy, output state_t res);
      int lat;
      bit seen, stable;
      @(negedge clk);
      din[i]      = st;
      in_valid[i] = 1'b1;
      chk("in_ready_before_accept", in_ready[i], 1'b1);
      @(posedge clk); #1;
      in_valid[i]  = 1'b0;
      din[i]       = ~st;
      out_ready[i] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 12) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid[i]) seen = 1'b1;
      end
      out_ready[i] = 1'b0;
      chk($sformatf("latency_cpc%0d", cpc_of(i)), lat, 4 / cpc_of(i));
      res    = dout[i];
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (dout[i] !== res || out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0) stable = 1'b0;
      end
      if (hold > 0) chk("backpressure_hold", stable, 1'b1);
      @(negedge clk);
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      out_ready[i] = 1'b0;
      chk("out_valid_drop", out_valid[i], 1'b0);
      chk("in_ready_after_handshake", in_ready[i], 1'b1);
      chk("dout_retained_idle", dout[i], res);
   endtask

   vec_t vecs [6];

   initial begin
      state_t res, orig;
      bit pulse;
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      state_t res, orig, fips_in;
      bit pulse;

      vecs[0] = '{"fips", mk(32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8),
                          mk(32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c)};
      vecs[1] = '{"all_01", {16{8'h01}}, {16{8'h01}}};
      vecs[2] = '{"all_c6", {16{8'hc6}}, {16{8'hc6}}};
      vecs[3] = '{"zero", '0, '0};
      vecs[4] = '{"fips_permuted", mk(32'h4d7ebdf8, 32'h8e4da1bc, 32'hd5d5d7d6, 32'h9fdc589d),
                                   mk(32'h2d26314c, 32'hdb135345, 32'hd4d4d4d5, 32'hf20a225c)};
      vecs[5] = '{"mixed_cols", mk(32'h01010101, 32'hc6c6c6c6, 32'h9fdc589d, 32'h00000000),
                                mk(32'h01010101, 32'hc6c6c6c6, 32'hf20a225c, 32'h00000000)};

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = 1'b0; out_ready[i] = 1'b0; din[i] = '1;
      end

      // Reset for two cycles
      repeat (2) begin
         @(negedge clk);
         chk("in_ready_in_reset", in_ready[0], 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         chk("out_valid_reset", out_valid[i], 1'b0);
         chk("dout_reset", dout[i], '0);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) chk("in_ready_after_reset", in_ready[i], 1'b1);

      // Directed table across all three column widths
      for (int i = 0; i < 3; i++) begin
         for (int v = 0; v < 6; v++) begin
            run_one(i, vecs[v].din, 0, 1'b0, res);
            chk($sformatf("%s_cpc%0d", vecs[v].name, cpc_of(i)), res, vecs[v].exp);
         end
      end

      // Backpressure on the 1-column instance
      run_one(0, vecs[0].din, 10, 1'b0, res);
      chk("backpressure_result", res, vecs[0].exp);

      // Reset after two columns have been processed
      fips_in = vecs[0].din;
      @(negedge clk);
      din[0] = fips_in; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("in_ready_mid_reset", in_ready[0], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      pulse = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (out_valid[0]) pulse = 1'b1;
      end
      chk("no_out_valid_after_reset", pulse, 1'b0);
      chk("dout_cleared_by_reset", dout[0], '0);
      run_one(0, vecs[4].din, 0, 1'b0, res);
      chk("post_reset_result", res, vecs[4].exp);

      // Random round trip: forward MixColumns then this block
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 200; n++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            run_one(i, fwd_mix(orig), $urandom_range(0, 3), 1'b1, res);
            chk($sformatf("roundtrip_cpc%0d_%0d", cpc_of(i), n), res, orig);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inv_mix_cols_seq.md
Name: inv_mix_cols_seq

Overview:
- Inverse MixColumns unit for the AES-128 decryption datapath; the counterpart of the forward MixCols transform.
- Accepts one 4x4 byte state and multiplies each column by the inverse constant matrix over GF(2^8), modulo x^8+x^4+x^3+x+1 (reduction constant 8'h1b).
- Processes COLS_PER_CYCLE columns per clock and uses valid/ready handshakes on input and output.
- Sits between InvShiftRows/InvSubBytes/AddRoundKey stages of the iterative decryption round.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  Datain holds a valid state
- in_ready  output  1  block can accept a state
- Datain  input  [7:0] [0:3][0:3]  input state, indexed [row][col]
- out_valid  output  1  Dataout holds a valid result
- out_ready  input  1  downstream accepts the result
- Dataout  output  [7:0] [0:3][0:3]  result state, indexed [row][col]

Behaviour:
- Reset, sampled at the clock edge while rst=1:
  - state goes to IDLE; column counter, working registers and Dataout clear to 0; out_valid=0.
  - in_ready=0 while rst=1.
  - Reset mid-operation discards the in-flight state; no partial output is ever presented.
- in_ready = (state==IDLE) && !rst, combinational.
- State IDLE:
  - On an edge with in_valid && in_ready, capture all 16 Datain bytes into working registers, clear col_cnt to 0, go to BUSY.
- State BUSY:
  - Each edge transforms columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in place.
  - col_cnt advances by COLS_PER_CYCLE.
  - On the edge that processes column 3, go to DONE with out_valid=1.
  - Datain and in_valid are ignored.
- State DONE:
  - out_valid=1 and Dataout is held stable until the edge where out_ready=1; that edge goes to IDLE with out_valid=0.
  - in_ready=0, so there is no accept in the same cycle as the output handshake.
- Latency: out_valid rises 4/COLS_PER_CYCLE edges after the accept edge (4, 2 or 1).
- Minimum initiation interval: 4/COLS_PER_CYCLE + 2 cycles when out_ready is held at 1.
- Column math, for column c with a0..a3 = rows 0..3:
  - r0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
  - r1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
  - r2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
  - r3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
- Multiplier construction:
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0), 8-bit result.
  - 09 = x8^x; 0b = x8^x2^x; 0d = x8^x4^x; 0e = x8^x4^x2, where x2=xtime(x), x4=xtime(x2), x8=xtime(x4).
  - All arithmetic is 8-bit XOR; no carries.
- Columns are independent: the result for column c depends only on input column c.
- Dataout changes only on the edge that enters DONE; it retains the last result while in IDLE.
- out_ready=1 in IDLE/BUSY has no effect. in_valid may drop before in_ready without side effects.

Test Plan:
- Reset then idle: assert rst for 2 cycles -> out_valid=0, Dataout all 00, in_ready=0 during rst and 1 on the cycle after rst deasserts.
- FIPS-197 column vectors, COLS_PER_CYCLE=1: columns {8e,4d,a1,bc}, {9f,dc,58,9d}, {d5,d5,d7,d6}, {4d,7e,bd,f8} -> outputs {db,13,53,45}, {f2,0a,22,5c}, {d4,d4,d4,d5}, {2d,26,31,4c}; out_valid exactly 4 edges after accept.
- Fixed points: all bytes 01 in every column, then all bytes c6 -> Dataout equals Datain; repeat with COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> Dataout stable and in_ready=0 throughout; pulse out_ready -> out_valid drops next cycle and in_ready=1.
- Reset mid-BUSY: assert rst after 2 columns -> no out_valid pulse; a new state accepted afterwards produces a correct result.
- Random round trip: 200 random states passed through a forward MixColumns model, then this block -> output equals the original state, with out_ready randomly toggled.
